// File: rtl/fifo_frame_reader_pkg.sv
// Shared constants for the FIFO frame reader.
// FRAME_LEN and TIMEOUT defaults track the GSM-switch frame definition.
package fifo_frame_reader_pkg;

  localparam int DBITWIDTH_DEF = 32;
  localparam int FRAME_LEN_DEF = 8;
  localparam int TIMEOUT_DEF   = 64;

  // Each buffered word carries {data, sop, eop}.
  localparam int TAG_W     = 2;
  localparam int SOP_BIT   = 1;
  localparam int EOP_BIT   = 0;

endpackage

// File: rtl/fifo_frame_reader_skid_buffer2.sv
// Generic 2-entry in-order valid/ready buffer.
// entry_p0 is always the head; entry_p1 holds the second word when occ==2.
module skid_buffer2 #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] entry_p0;
  logic [WIDTH-1:0] entry_p1;
  logic             push;
  logic             pop;

  assign out_valid = (occ != 2'd0);
  assign out_data  = entry_p0;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (occ != 2'd2);

  always_ff @(posedge clk) begin
    if (clr) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset: occ alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (occ == 2'd2) begin
        entry_p0 <= entry_p1;
      end else if (push) begin
        entry_p0 <= in_data;
      end
    end else if (push) begin
      if (occ == 2'd0) begin
        entry_p0 <= in_data;
      end else begin
        entry_p1 <= in_data;
      end
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Read-side FIFO consumer: pops words, tags them into fixed-length frames and
// streams them out; a frame that stalls mid-way is aborted and framing realigned.
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DBITWIDTH = DBITWIDTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic [DBITWIDTH-1:0] fifo_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DBITWIDTH-1:0] out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 timeout_err,
  output logic [15:0]          frame_count
);

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int WORD_W = DBITWIDTH + TAG_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  logic [1:0]        occ;
  logic [IDX_W-1:0]  enq_idx;
  logic [TO_W-1:0]   to_cnt;
  logic [WORD_W-1:0] enq_word;
  logic [WORD_W-1:0] head_word;
  logic              mid_frame;
  logic              abort;
  logic              deq;

  // The FIFO read port is unregistered, so the popped word is captured this cycle.
  assign fifo_read = ~clr & ~fifo_empty & (occ < 2'd2);
  assign enq_word  = {fifo_data, (enq_idx == '0), (enq_idx == LAST_IDX)};

  skid_buffer2 #(
    .WIDTH (WORD_W)
  ) u_skid (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (fifo_read),
    .in_data   (enq_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_word),
    .occ       (occ)
  );

  assign out_data = head_word[WORD_W-1:TAG_W];
  assign out_sop  = out_valid & head_word[SOP_BIT];
  assign out_eop  = out_valid & head_word[EOP_BIT];
  assign deq      = out_valid & out_ready;

  // Abort fires in the cycle that would bring the stall count to TIMEOUT;
  // it needs fifo_empty, so it can never coincide with a pop.
  assign mid_frame   = (enq_idx != '0);
  assign abort       = ~clr & fifo_empty & mid_frame & (to_cnt == TO_LAST);
  assign timeout_err = abort;

  always_ff @(posedge clk) begin
    if (clr) begin
      enq_idx     <= '0;
      to_cnt      <= '0;
      frame_count <= 16'd0;
    end else begin
      if (fifo_read) begin
        enq_idx <= (enq_idx == LAST_IDX) ? '0 : enq_idx + 1'b1;
      end else if (abort) begin
        enq_idx <= '0;
      end

      if (fifo_read || !mid_frame || abort) begin
        to_cnt <= '0;
      end else if (fifo_empty) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (deq && head_word[EOP_BIT]) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: a FIFO model feeds the DUT, a
// frame-position model predicts each word's tags, and a monitor compares.
module tb_fifo_frame_reader;

  localparam int DW = 32;
  localparam int FL = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr;
  logic          fifo_empty;
  logic          fifo_read;
  logic [DW-1:0] fifo_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          timeout_err;
  logic [15:0]   frame_count;

  fifo_frame_reader #(.DBITWIDTH(DW), .FRAME_LEN(FL), .TIMEOUT(TO)) u_dut (
    .clk(clk), .clr(clr), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_data(fifo_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  // Small second build: two-word frames, single-cycle stall tolerance.
  logic          clr2;
  logic          fifo_empty2;
  logic          fifo_read2;
  logic [DW-1:0] fifo_data2;
  logic          out_valid2;
  logic          out_ready2 = 1'b1;
  logic [DW-1:0] out_data2;
  logic          out_sop2;
  logic          out_eop2;
  logic          timeout_err2;
  logic [15:0]   frame_count2;

  fifo_frame_reader #(.DBITWIDTH(DW), .FRAME_LEN(2), .TIMEOUT(1)) u_dut2 (
    .clk(clk), .clr(clr2), .fifo_empty(fifo_empty2), .fifo_read(fifo_read2),
    .fifo_data(fifo_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_sop(out_sop2), .out_eop(out_eop2),
    .timeout_err(timeout_err2), .frame_count(frame_count2)
  );

  // FIFO models: the bench writes, the DUT's pop strobe advances the read side.
  logic [DW-1:0] mem [0:4095];
  logic [31:0]   wr_ptr = 32'd0;
  logic [31:0]   rd_ptr = 32'd0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[11:0]];
  always @(posedge clk) if (fifo_read) rd_ptr <= rd_ptr + 32'd1;

  logic [3:0] rd2 = 4'd0;
  logic [3:0] avail2 = 4'd0;
  assign fifo_empty2 = (rd2 >= avail2);
  assign fifo_data2  = 32'hA0 + {28'd0, rd2};
  always @(posedge clk) if (fifo_read2) rd2 <= rd2 + 4'd1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp_w;
  int          checks = 0;
  int          passes = 0;
  int          fails = 0;
  int          pos = 0;
  int          run = 0;
  logic [15:0] exp_frames = 16'd0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          tmo_gap = -1;
  int          tmo_seen = 0;
  int          pops_total = 0;
  int          k2 = 0;
  bit          prev_clr = 1'b0;
  bit          prev_pop = 1'b0;
  bit          exp_tmo;

  string       xr_name;
  logic [63:0] xr_act;
  logic [63:0] xr_exp;
  int          xr_n = 0;
  int          xr_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model, evaluated mid-cycle on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (xr_n != xr_done) begin
      check(xr_name, xr_act, xr_exp);
      xr_done = xr_n;
    end

    if (clr) begin
      check("read_in_clr", {63'd0, fifo_read}, 64'd0);
      exp_q.delete();
      pos = 0;
      run = 0;
      exp_frames = 16'd0;
      prev_pop = 1'b0;
      prev_clr = 1'b1;
    end else begin
      if (prev_clr) begin
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sop", {63'd0, out_sop}, 64'd0);
        check("rst_eop", {63'd0, out_eop}, 64'd0);
        check("rst_tmo", {63'd0, timeout_err}, 64'd0);
        check("rst_frames", {48'd0, frame_count}, 64'd0);
      end
      if (prev_pop) check("latency", {63'd0, out_valid}, 64'd1);
      check("pop_rule", {63'd0, fifo_read}, {63'd0, (!fifo_empty && exp_q.size() < 2)});
      check("valid", {63'd0, out_valid}, {63'd0, (exp_q.size() != 0)});
      exp_tmo = (pos != 0) && fifo_empty && (run == TO - 1);
      check("timeout", {63'd0, timeout_err}, {63'd0, exp_tmo});
      check("frames", {48'd0, frame_count}, {48'd0, exp_frames});

      if (out_valid && exp_q.size() != 0) begin
        check("data", {32'd0, out_data}, {32'd0, exp_q[0].d});
        check("sop", {63'd0, out_sop}, {63'd0, exp_q[0].s});
        check("eop", {63'd0, out_eop}, {63'd0, exp_q[0].e});
        if (out_ready) begin
          if (exp_q[0].e) exp_frames = exp_frames + 16'd1;
          void'(exp_q.pop_front());
        end
      end

      prev_pop = fifo_read;
      if (fifo_read) begin
        exp_w.d = fifo_data;
        exp_w.s = (pos == 0);
        exp_w.e = (pos == FL - 1);
        exp_q.push_back(exp_w);
        pos = (pos + 1) % FL;
        run = 0;
        pops_total++;
        last_pop_cyc = cyc;
      end else if (exp_tmo) begin
        pos = 0;
        run = 0;
      end else if (pos != 0 && fifo_empty) begin
        run++;
      end
      if (timeout_err) begin
        tmo_seen++;
        tmo_gap = cyc - last_pop_cyc;
      end
      prev_clr = 1'b0;
    end

    if (!clr2) begin
      check("d2_tmo", {63'd0, timeout_err2}, 64'd0);
      if (out_valid2) begin
        check("d2_data", {32'd0, out_data2}, 64'hA0 + k2);
        check("d2_sop", {63'd0, out_sop2}, {63'd0, (k2 % 2 == 0)});
        check("d2_eop", {63'd0, out_eop2}, {63'd0, (k2 % 2 == 1)});
        k2++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr = wr_ptr + 32'd1;
  endtask

  task automatic xcheck(input string name, input logic [63:0] act, input logic [63:0] exp);
    xr_name = name;
    xr_act  = act;
    xr_exp  = exp;
    xr_n++;
    tick;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && !(rd_ptr == wr_ptr && exp_q.size() == 0)) begin
      tick;
      n++;
    end
    xcheck("drain_left", {32'd0, wr_ptr - rd_ptr} + exp_q.size(), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int t0;
    int p0;
    clr = 1'b1;
    clr2 = 1'b1;
    out_ready = 1'b1;

    // Preloaded stream, two full frames.
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    repeat (3) tick;
    clr = 1'b0;
    drain(100);
    xcheck("p1_frames", {48'd0, frame_count}, 64'd2);

    // Backpressure: only two words may leave the FIFO unaccepted.
    out_ready = 1'b0;
    p0 = pops_total;
    for (int i = 0; i < 8; i++) push_word(32'h200 + DW'(i));
    repeat (10) tick;
    xcheck("bp_pops", 64'(pops_total - p0), 64'd2);
    xcheck("bp_hold", {32'd0, out_data}, 64'h200);
    out_ready = 1'b1;
    drain(100);
    xcheck("p2_frames", {48'd0, frame_count}, 64'd3);

    // Stall mid-frame long enough to abort it.
    t0 = tmo_seen;
    for (int i = 0; i < 3; i++) push_word(32'h300 + DW'(i));
    repeat (TO + 5) tick;
    xcheck("tmo_pulses", 64'(tmo_seen - t0), 64'd1);
    xcheck("tmo_gap", 64'(tmo_gap), 64'(TO));
    xcheck("tmo_frames", {48'd0, frame_count}, 64'd3);
    for (int i = 0; i < 8; i++) push_word(32'h400 + DW'(i));
    drain(100);
    xcheck("p3_frames", {48'd0, frame_count}, 64'd4);

    // out_ready toggling every cycle across three frames.
    for (int i = 0; i < 24; i++) push_word($urandom);
    for (int i = 0; i < 80; i++) begin
      out_ready = ~out_ready;
      tick;
    end
    out_ready = 1'b1;
    drain(100);
    xcheck("p4_frames", {48'd0, frame_count}, 64'd7);

    // Clear with the buffer full in the middle of a frame.
    out_ready = 1'b0;
    p0 = pops_total;
    for (int i = 0; i < 5; i++) push_word(32'h500 + DW'(i));
    repeat (6) tick;
    xcheck("p5_full", 64'(pops_total - p0), 64'd2);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    tick;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(32'h510 + DW'(i));
    drain(100);
    xcheck("p5_frames", {48'd0, frame_count}, 64'd1);

    // Random traffic with one quiet window longer than the timeout.
    for (int i = 0; i < 400; i++) begin
      if (!(i >= 150 && i < 150 + TO + 10) && $urandom_range(0, 9) < 4) push_word($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick;
    end
    out_ready = 1'b1;
    drain(300);

    // Two-word frames on the second build.
    clr2 = 1'b0;
    tick;
    avail2 = 4'd6;
    repeat (12) tick;
    xcheck("d2_frames", {48'd0, frame_count2}, 64'd3);
    xcheck("d2_words", 64'(k2), 64'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Read-side consumer for the asynchronous clock-crossing FIFO, running in that FIFO's read clock domain.
- Pops words from the FIFO's unregistered read port and groups them into fixed-length frames.
- Presents frames downstream on a valid/ready stream with start-of-frame and end-of-frame marks.
- Detects frames that stall mid-way (FIFO stays empty too long) and realigns framing.

Parameters:
- DBITWIDTH, 32, data word width; must match the FIFO.
- FRAME_LEN, 8, words per frame; must be at least 2.
- TIMEOUT, 64, consecutive empty cycles allowed mid-frame before abort; must be at least 1.
- Local constants, derived and not overridable: IDX_W = $clog2(FRAME_LEN); TO_W = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock, the FIFO read-side clock.
- clr  in  1  reset, synchronous, active-high; clears all state.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  out  1  pop strobe to the FIFO.
- fifo_data  in  DBITWIDTH  FIFO read data; valid in the same cycle fifo_read is high (unregistered RAM read).
- out_valid  out  1  downstream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DBITWIDTH  downstream word.
- out_sop  out  1  first word of a frame; qualified by out_valid.
- out_eop  out  1  last word of a frame; qualified by out_valid.
- timeout_err  out  1  one-cycle pulse when a stalled frame is aborted.
- frame_count  out  16  count of complete frames delivered; wraps at 16'hFFFF to 0.

Behaviour:
- Reset: while clr is high, fifo_read=0. On the first cycle after clr, out_valid=0, out_sop=0, out_eop=0, timeout_err=0, frame_count=0, buffer occupancy=0, enq_idx=0, timeout counter=0. clr applied mid-frame discards buffered words with no eop emitted. clr does not clear the FIFO; the FIFO is cleared by its own clear input.
- Output buffer: 2-entry in-order skid buffer holding {data, sop, eop}. occ is in 0..2. out_valid = (occ != 0); outputs come from the head entry.
- Pop rule: fifo_read = ~clr & ~fifo_empty & (occ < 2). There is no combinational path from out_ready to fifo_read.
- Enqueue: when fifo_read=1, fifo_data is captured in that same cycle with sop=(enq_idx==0) and eop=(enq_idx==FRAME_LEN-1).
- Frame index: enq_idx increments on each enqueue and wraps to 0 after FRAME_LEN-1.
- Dequeue: happens when out_valid & out_ready.
  - Simultaneous enqueue and dequeue leaves occ unchanged.
  - With occ=1, this sustains 1 word/clk throughput.
- Latency: FIFO word to out_valid is 1 clk when the buffer is empty.
- Backpressure: out_ready low holds out_data, out_sop and out_eop stable while out_valid=1. At most 2 words are ever popped without being accepted downstream.
- frame_count: increments by 1 on every dequeue whose entry has eop=1.
- Timeout counter: counts cycles with enq_idx != 0 & fifo_empty. It resets to 0 on any enqueue, or when enq_idx == 0.
- Timeout abort: when the counter reaches TIMEOUT:
  - timeout_err pulses high for 1 clk;
  - enq_idx is forced to 0, so the next word popped is marked sop;
  - the counter resets to 0.
  - Words of the aborted partial frame already in the buffer are still delivered, without eop, and are not counted in frame_count.
- Timeout and enqueue in the same cycle cannot occur: enqueue requires ~fifo_empty.
- State summary: framing is tracked only by enq_idx (IDX_W bits). No FSM beyond {occ, enq_idx, timeout counter}.

Decomposition:
- Shared package: no typedefs. FRAME_LEN and TIMEOUT defaults belong with the GSM-switch frame constants header.
- One natural sub-module: skid_buffer2, a generic 2-entry valid/ready buffer of width DBITWIDTH+2. The top level holds pop logic, frame index, timeout and frame_count.

Test Plan:
- Reset then 16 words 0x0..0xF preloaded, out_ready=1 -> 16 consecutive out_valid cycles starting 1 clk after the first fifo_read; sop on words 0x0 and 0x8; eop on 0x7 and 0xF; frame_count=2.
- Backpressure: out_ready=0 with 8 words available -> exactly 2 fifo_read pulses; out_data=word0 stable. Then out_ready=1 -> remaining 6 words delivered in order, no loss or duplicate.
- Stall: 3 words written, then none for TIMEOUT+5 cycles -> timeout_err pulses exactly once, TIMEOUT cycles after the 3rd pop. Next written word is out with sop=1; frame_count unchanged.
- Toggle out_ready every cycle over 3 frames -> data order preserved, sop/eop on correct words, frame_count=3.
- clr asserted while occ=2 mid-frame -> next cycle out_valid=0, frame_count=0. Next word popped carries sop=1.
- FRAME_LEN=2, TIMEOUT=1 build: continuous stream of 6 words -> sop/eop alternate every word; frame_count=3.
